hls_cnn_2d_100s_sdiv_30s_14s_16_seq: RTL and testbench

- Sequential signed fixed-point divider: the inverse of the 16s x 14s -> 30 product path.
- Divides a 30-bit signed accumulator/product by a 14-bit signed scale and returns a saturated 16-bit signed quotient plus a 14-bit signed remainder.
- Used for requantisation/normalisation after conv/dense accumulation.
- Radix-2 restoring, one quotient bit per cycle, valid/ready handshake on both sides.

---
 rtl/hls_cnn_2d_100s_sdiv_30s_14s_16_seq.sv | 148 ++++++++++++++
 tb/tb_hls_cnn_2d_100s_sdiv_30s_14s_16_seq.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hls_cnn_2d_100s_sdiv_30s_14s_16_seq.sv
// Sequential radix-2 restoring signed divider with a saturated quotient, producing one quotient bit per cycle.
// Signs are stripped on accept, and the magnitudes are divided and then re-signed and clipped in FIX.
module hls_cnn_2d_100s_sdiv_30s_14s_16_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 30,
    parameter int din1_WIDTH = 14,
    parameter int dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] quot,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  div0
);
    localparam int CNT_W = $clog2(din0_WIDTH);
    localparam logic [din0_WIDTH-1:0] QPOS_MAX = din0_WIDTH'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
    localparam logic [din0_WIDTH-1:0] QNEG_MAG = din0_WIDTH'(64'd1 << (dout_WIDTH - 1));
    localparam logic [dout_WIDTH-1:0] SAT_POS  = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] SAT_NEG  = {1'b1, {(dout_WIDTH-1){1'b0}}};

    if (dout_WIDTH > din0_WIDTH || din1_WIDTH >= din0_WIDTH || ID < 0) begin : g_bad_cfg
        $error("hls_cnn_2d_100s_sdiv_30s_14s_16_seq: unsupported width configuration");
    end

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                  state_reg, state_next;
    logic [din0_WIDTH-1:0]   dvd_reg;   // dividend shifts out MSB-first while quotient bits shift in
    logic [din1_WIDTH-1:0]   dvs_reg;
    logic [din1_WIDTH:0]     pr_reg;
    logic                    sign0_reg, sign1_reg, zero_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [dout_WIDTH-1:0]   quot_reg;
    logic [din1_WIDTH-1:0]   rem_reg;
    logic                    ovf_reg, div0_reg;

    logic [din1_WIDTH+1:0]   pr_ext, dvs_ext;
    logic                    q_bit;
    logic                    neg_q;
    logic                    q_clip;
    logic [dout_WIDTH-1:0]   q_signed;

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = CALC;
            CALC:    if (cnt_reg == '0) state_next = FIX;
            FIX:     state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state_reg == IDLE);
        out_valid = (state_reg == DONE);
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        pr_ext  = {pr_reg, dvd_reg[din0_WIDTH-1]};
        dvs_ext = {2'b00, dvs_reg};
        q_bit   = (pr_ext >= dvs_ext);
    end

    // Re-sign and clip the quotient magnitude
    always_comb begin
        neg_q    = sign0_reg ^ sign1_reg;
        q_clip   = neg_q ? (dvd_reg > QNEG_MAG) : (dvd_reg > QPOS_MAX);
        q_signed = neg_q ? dout_WIDTH'(-dvd_reg) : dvd_reg[dout_WIDTH-1:0];
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            dvd_reg   <= '0;
            dvs_reg   <= '0;
            pr_reg    <= '0;
            sign0_reg <= 1'b0;
            sign1_reg <= 1'b0;
            zero_reg  <= 1'b0;
            cnt_reg   <= '0;
            quot_reg  <= '0;
            rem_reg   <= '0;
            ovf_reg   <= 1'b0;
            div0_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        dvd_reg   <= din0[din0_WIDTH-1] ? -din0 : din0;
                        dvs_reg   <= din1[din1_WIDTH-1] ? -din1 : din1;
                        pr_reg    <= '0;
                        sign0_reg <= din0[din0_WIDTH-1];
                        sign1_reg <= din1[din1_WIDTH-1];
                        zero_reg  <= (din1 == '0);
                        cnt_reg   <= CNT_W'(din0_WIDTH - 1);
                    end
                end
                CALC: begin
                    dvd_reg <= {dvd_reg[din0_WIDTH-2:0], q_bit};
                    pr_reg  <= q_bit ? (din1_WIDTH+1)'(pr_ext - dvs_ext)
                                     : (din1_WIDTH+1)'(pr_ext);
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                FIX: begin
                    if (zero_reg) begin
                        quot_reg <= sign0_reg ? SAT_NEG : SAT_POS;
                        rem_reg  <= '0;
                        ovf_reg  <= 1'b0;
                        div0_reg <= 1'b1;
                    end else begin
                        quot_reg <= q_clip ? (neg_q ? SAT_NEG : SAT_POS) : q_signed;
                        rem_reg  <= sign0_reg ? din1_WIDTH'(-pr_reg) : din1_WIDTH'(pr_reg);
                        ovf_reg  <= q_clip;
                        div0_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quot = quot_reg;
    assign rem  = rem_reg;
    assign ovf  = ovf_reg;
    assign div0 = div0_reg;

endmodule

// File: tb/tb_hls_cnn_2d_100s_sdiv_30s_14s_16_seq.sv
// Scoreboard bench for the sequential signed divider: stimulus pushes expected results,
// and a negedge monitor pops them on each output handshake and also checks the 31-cycle latency.
module tb_hls_cnn_2d_100s_sdiv_30s_14s_16_seq;
    logic        ap_clk = 1'b0;
    logic        ap_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] din0 = '0;
    logic [13:0] din1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] quot;
    logic [13:0] rem;
    logic        ovf;
    logic        div0;

    hls_cnn_2d_100s_sdiv_30s_14s_16_seq #(
        .ID(1), .din0_WIDTH(30), .din1_WIDTH(14), .dout_WIDTH(16)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .din0(din0), .din1(din1),
        .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .rem(rem), .ovf(ovf), .div0(div0)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        int q;
        int r;
        bit ovf;
        bit dz;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // Monitor: latency on the rising edge of out_valid, data on each handshake
    always @(negedge ap_clk) begin
        if (!ap_rst) begin
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    chk("latency", cyc - sb[0].acc, 31);
                end
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                $display("TXN quot=%0d rem=%0d ovf=%0b div0=%0b exp_quot=%0d exp_rem=%0d",
                         $signed(quot), $signed(rem), ovf, div0, e.q, e.r);
                chk("quot", longint'($signed(quot)), e.q);
                chk("rem",  longint'($signed(rem)),  e.r);
                chk("ovf",  ovf,  e.ovf);
                chk("div0", div0, e.dz);
            end
        end
        prev_valid = out_valid;
    end

    task automatic issue(input int a, input int b, input bit push,
                         input int eq, input int er, input bit eovf, input bit edz);
        int n;
        exp_t e;
        n = 0;
        @(negedge ap_clk);
        while (!in_ready && n < 200) begin
            @(negedge ap_clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("issue_wait_ready");
        end else begin
            in_valid = 1'b1;
            din0 = 30'(a);
            din1 = 14'(b);
            @(posedge ap_clk);
            #1;
            in_valid = 1'b0;
            if (push) begin
                e.q = eq; e.r = er; e.ovf = eovf; e.dz = edz; e.acc = cyc;
                sb.push_back(e);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 300) begin
            @(negedge ap_clk);
            n++;
        end
        if (sb.size() != 0 || !in_ready) fail_now("drain");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [31:0] snap;

        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quot",      quot,      0);
        chk("rst_rem",       rem,       0);
        chk("rst_flags",     {ovf, div0}, 0);
        ap_rst = 1'b0;

        // Basic division with busy check
        issue(1000, 7, 1, 142, 6, 0, 0);
        repeat (15) @(negedge ap_clk);
        chk("busy_in_ready", in_ready, 0);
        drain();

        // Sign combinations and quotient edges
        issue(-1000,  7, 1, -142, -6, 0, 0);
        issue( 1000, -7, 1, -142,  6, 0, 0);
        issue(-1000, -7, 1,  142, -6, 0, 0);
        issue( 65534,  2, 1,  32767, 0, 0, 0);
        issue(-65536,  2, 1, -32768, 0, 0, 0);
        issue(-65538,  2, 1, -32768, 0, 1, 0);
        drain();

        // Saturation
        issue(1 << 20, 1, 1, 32767, 0, 1, 0);
        issue(-(1 << 29), 1, 1, -32768, 0, 1, 0);
        issue(-(1 << 29), -8192, 1, 32767, 0, 1, 0);
        drain();

        // Divide by zero
        issue( 5, 0, 1,  32767, 0, 0, 1);
        issue(-5, 0, 1, -32768, 0, 0, 1);
        drain();

        // Backpressure: hold outputs, ignore new operands
        @(posedge ap_clk);
        #1 out_ready = 1'b0;
        issue(1000, 7, 1, 142, 6, 0, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        if (!out_valid) fail_now("bp_wait_valid");
        snap = {quot, rem, ovf, div0};
        in_valid = 1'b1;
        din0 = 30'd77;
        din1 = 14'd5;
        repeat (10) begin
            @(negedge ap_clk);
            chk("bp_hold",      {quot, rem, ovf, div0}, snap);
            chk("bp_in_ready",  in_ready,  0);
            chk("bp_out_valid", out_valid, 1);
        end
        @(posedge ap_clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge ap_clk);
        @(negedge ap_clk);
        chk("release_out_valid", out_valid, 0);
        chk("release_in_ready",  in_ready,  1);
        drain();

        // Reset mid-operation aborts the division
        issue(1000, 7, 0, 0, 0, 0, 0);
        repeat (12) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("midrst_in_ready",  in_ready,  1);
        chk("midrst_out_valid", out_valid, 0);
        repeat (40) @(negedge ap_clk);
        issue(100, 3, 1, 33, 1, 0, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
